fma_write_buffer: RTL and testbench
===================================

FMA_WRITE_BUFFER -- requirements
Module: fma_write_buffer

Interface
REQ-001: Parameters SHALL be: FMA_COUNT, default 2, number of FMAs per result set; WORD_WIDTH, default 16, bits per word; LINE_WIDTH, default 96, equal to FMA_COUNT*3*WORD_WIDTH.
REQ-002: The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003: Port clk_in, input, 1 bit: the single clock.
REQ-004: Port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005: Port fma_c_in, input, FMA_COUNT*WORD_WIDTH bits: one result set; FMA i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-006: Port fma_c_valid_in, input, 1 bit: fma_c_in is valid this cycle.
REQ-007: Port flush_in, input, 1 bit: publish a partially filled line.
REQ-008: Port line_ack_in, input, 1 bit: memory has consumed line_out.
REQ-009: Port line_out, output, LINE_WIDTH bits: the packed line.
REQ-010: Port line_valid_out, output, 1 bit: line_out is valid.
REQ-011: Port overflow_out, output, 1 bit: sticky flag, a result set was dropped.

Function
REQ-012: Line layout SHALL place result set k (k=0,1,2, in arrival order) at bits [k*FMA_COUNT*WORD_WIDTH +: FMA_COUNT*WORD_WIDTH].
- Within each slot, FMA i SHALL sit at +i*WORD_WIDTH.
- Word order from the top: fma_2_c_3 fma_1_c_3 ... fma_1_c_1.
REQ-013: An accumulator register and a fill counter SHALL be kept.
- Fill counter states: EMPTY=0, ONE=1, TWO=2, FULL=3.
- On a valid cycle with fill < 3, fma_c_in SHALL be written to slot fill and fill SHALL increment.
REQ-014: Output states SHALL be IDLE (line_valid_out=0) and HELD (line_valid_out=1).
- In HELD, line_out SHALL stay stable until line_ack_in is sampled high.
REQ-015: A completed line SHALL transfer to line_out when the output is free.
- A line completes when the third set is captured, or on a qualifying flush.
- The output is free in IDLE, or in HELD with line_ack_in high in the same cycle.
- Latency: line_valid_out SHALL be high in the cycle after the completing edge.
- On transfer, the accumulator SHALL clear to zero and fill SHALL return to EMPTY.
REQ-016: If a line completes while the output is not free, the accumulator SHALL hold with fill=FULL.
- The held line SHALL transfer on the edge where line_ack_in is high.
- line_valid_out SHALL stay high across that edge with the new data, with no bubble.
REQ-017: A fma_c_valid_in arriving while fill=FULL SHALL be dropped and SHALL set the overflow flag.
- If line_ack_in is high in that same cycle, the set is still dropped, because the transfer frees the accumulator only at that edge.
REQ-018: flush_in with fill of 1 or 2 SHALL complete the line; unwritten slots SHALL be zero.
- flush_in with fill of 0 or 3 SHALL be a no-op.
REQ-019: If flush_in and fma_c_valid_in are high together, the set SHALL be captured first and the flush then applied to the resulting fill.
- Example: from fill=1, a concurrent set and flush publish a two-slot line.
REQ-020: line_ack_in while IDLE SHALL be ignored.
REQ-021: HELD with line_ack_in high and no pending line SHALL return to IDLE next cycle.

Reset
REQ-022: Asserting rst_in low SHALL immediately force the following, regardless of clk_in:
- line_out=0, line_valid_out=0, overflow_out=0;
- accumulator=0, fill=EMPTY.
REQ-023: A reset mid-operation SHALL discard any partial and held lines without emitting them.
REQ-024: Deassertion SHALL be sampled synchronously; the first capture SHALL occur on the first edge after release.

Configuration
REQ-025: Macro FMA_WRITE_BUFFER_OVERFLOW_EN SHALL control overflow reporting.
- Defined: overflow_out is set by any REQ-017 drop and is cleared only by reset.
- Undefined: overflow_out is tied to 0; drops still occur silently.

Verification
REQ-026: Sets 0x0401_0402, 0x0403_0404, 0x0405_0406 on consecutive cycles, output idle -> one cycle after the third set, line_valid_out=1 and line_out=0x0405_0406_0403_0404_0401_0402; held until ack.
REQ-027: Hold line_ack_in low, send 6 sets -> first line held; second line waits in the accumulator (fill=FULL); ack pulse -> line_out switches to the second line the next cycle with line_valid_out continuously high.
REQ-028: While fill=FULL and HELD, send a 7th set -> it is dropped; overflow_out=1 with macro defined, 0 without; subsequent lines are unaffected.
REQ-029: Send 0x1111_2222, then flush_in -> line_out=0x0000_0000_0000_0000_1111_2222 next cycle; flush at fill=0 -> no output.
REQ-030: Send two sets, then pull rst_in low mid-cycle -> all outputs 0 immediately; after release, three new sets yield a line containing only the new data.

Source files
------------

// File: rtl/fma_write_buffer_if.sv
// Bus between an FMA result producer, the line-packing write buffer and memory.
// Producer side drives results, flush and ack; the buffer drives the packed line and status.
interface fma_write_buffer_if #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16
);
    localparam int SET_W  = FMA_COUNT * WORD_WIDTH;
    localparam int LINE_W = 3 * SET_W;

    logic [SET_W-1:0]  fma_c_in;
    logic              fma_c_valid_in;
    logic              flush_in;
    logic              line_ack_in;
    logic [LINE_W-1:0] line_out;
    logic              line_valid_out;
    logic              overflow_out;

    modport master (
        output fma_c_in, fma_c_valid_in, flush_in, line_ack_in,
        input  line_out, line_valid_out, overflow_out
    );

    modport slave (
        input  fma_c_in, fma_c_valid_in, flush_in, line_ack_in,
        output line_out, line_valid_out, overflow_out
    );
endinterface

// File: rtl/fma_write_buffer.sv
// Packs three FMA result sets into one memory line and holds it until acknowledged.
// Define FMA_WRITE_BUFFER_OVERFLOW_EN to report dropped result sets on overflow_out.
module fma_write_buffer #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    fma_write_buffer_if.slave       bus
);
    localparam int SET_W = FMA_COUNT * WORD_WIDTH;

    typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_t;
    typedef enum logic       {IDLE, HELD}            out_state_t;

    logic [LINE_WIDTH-1:0] acc_q, acc_d, acc_cap;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    fill_t                 fill_q, fill_d, fill_cap;
    out_state_t            state_q, state_d;
    logic                  complete;
    logic                  out_free;

    // Capture stage: the incoming set lands first, so a concurrent flush sees the new fill.
    always_comb begin
        acc_cap  = acc_q;
        fill_cap = fill_q;
        if (bus.fma_c_valid_in && fill_q != FULL) begin
            case (fill_q)
                EMPTY:   acc_cap[0       +: SET_W] = bus.fma_c_in;
                ONE:     acc_cap[SET_W   +: SET_W] = bus.fma_c_in;
                TWO:     acc_cap[2*SET_W +: SET_W] = bus.fma_c_in;
                default: ;
            endcase
            fill_cap = fill_t'(fill_q + 2'd1);
        end
    end

    assign complete = (fill_cap == FULL) ||
                      (bus.flush_in && (fill_cap == ONE || fill_cap == TWO));
    assign out_free = (state_q == IDLE) || bus.line_ack_in;

    always_comb begin
        acc_d   = acc_cap;
        fill_d  = fill_cap;
        line_d  = line_q;
        state_d = state_q;
        if (state_q == HELD && bus.line_ack_in) state_d = IDLE;
        if (complete) begin
            if (out_free) begin
                line_d  = acc_cap;
                state_d = HELD;
                acc_d   = '0;
                fill_d  = EMPTY;
            end else begin
                // A flushed partial line parks as FULL too, so nothing else is accepted.
                fill_d = FULL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the wide accumulator and line registers are reset because a reset must discard them.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_q   <= '0;
            fill_q  <= EMPTY;
            line_q  <= '0;
            state_q <= IDLE;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            line_q  <= line_d;
            state_q <= state_d;
        end
    end

    assign bus.line_out       = line_q;
    assign bus.line_valid_out = (state_q == HELD);

`ifdef FMA_WRITE_BUFFER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // The accumulator frees only at the transfer edge, so an ack does not rescue a set.
    always_comb overflow_d = overflow_q | (bus.fma_c_valid_in && fill_q == FULL);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    assign bus.overflow_out = overflow_q;
`else
    assign bus.overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_fma_write_buffer.sv
// Directed bench for fma_write_buffer: packing, hold/ack, back-pressure drops, flush and reset.
module tb_fma_write_buffer;
    logic clk_in;
    logic rst_in;
    int   total;
    int   passed;
    int   failed;

`ifdef FMA_WRITE_BUFFER_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    fma_write_buffer_if #(.FMA_COUNT(2), .WORD_WIDTH(16)) bus ();

    fma_write_buffer #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bus.fma_c_in       = d;
        bus.fma_c_valid_in = 1'b1;
        tick();
        bus.fma_c_valid_in = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.line_ack_in = 1'b1;
        tick();
        bus.line_ack_in = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        bus.fma_c_in       = '0;
        bus.fma_c_valid_in = 1'b0;
        bus.flush_in       = 1'b0;
        bus.line_ack_in    = 1'b0;
        rst_in             = 1'b1;
        #1 rst_in = 1'b0;
        #2;
        check("rst_line",  bus.line_out, 96'h0);
        check("rst_valid", 96'(bus.line_valid_out), 96'h0);
        check("rst_ovf",   96'(bus.overflow_out), 96'h0);
        repeat (2) @(posedge clk_in);
        #4 rst_in = 1'b1;

        // Three consecutive sets, output idle.
        send(32'h0401_0402);
        send(32'h0403_0404);
        check("valid_before_third", 96'(bus.line_valid_out), 96'h0);
        send(32'h0405_0406);
        check("basic_valid", 96'(bus.line_valid_out), 96'h1);
        check("basic_line",  bus.line_out, 96'h0405_0406_0403_0404_0401_0402);
        tick();
        check("basic_held",  bus.line_out, 96'h0405_0406_0403_0404_0401_0402);
        check("basic_held_valid", 96'(bus.line_valid_out), 96'h1);
        ack_pulse();
        check("basic_ack_idle", 96'(bus.line_valid_out), 96'h0);
        ack_pulse();
        check("ack_in_idle_ignored", 96'(bus.line_valid_out), 96'h0);

        // Back-pressure: six sets with ack low, then drops while full and held.
        send(32'h1000_0001);
        send(32'h1000_0002);
        send(32'h1000_0003);
        check("bp_first_line", bus.line_out, 96'h1000_0003_1000_0002_1000_0001);
        send(32'h2000_0004);
        send(32'h2000_0005);
        send(32'h2000_0006);
        check("bp_first_still_held", bus.line_out, 96'h1000_0003_1000_0002_1000_0001);
        check("bp_valid_held", 96'(bus.line_valid_out), 96'h1);
        check("bp_no_ovf_yet", 96'(bus.overflow_out), 96'h0);
        send(32'hDEAD_BEEF);
        check("ovf_after_drop", 96'(bus.overflow_out), 96'(EXP_OVF));
        bus.line_ack_in = 1'b1;
        send(32'hCAFE_F00D);
        bus.line_ack_in = 1'b0;
        check("bp_second_valid", 96'(bus.line_valid_out), 96'h1);
        check("bp_second_line", bus.line_out, 96'h2000_0006_2000_0005_2000_0004);
        ack_pulse();
        check("bp_drained", 96'(bus.line_valid_out), 96'h0);
        check("ovf_sticky", 96'(bus.overflow_out), 96'(EXP_OVF));
        send(32'h3000_0009);
        send(32'h3000_000A);
        send(32'h3000_000B);
        check("after_drop_line", bus.line_out, 96'h3000_000B_3000_000A_3000_0009);
        ack_pulse();

        // Flush of a one-slot line, flush when empty, concurrent set and flush.
        send(32'h1111_2222);
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        check("flush1_valid", 96'(bus.line_valid_out), 96'h1);
        check("flush1_line", bus.line_out, 96'h0000_0000_0000_0000_1111_2222);
        ack_pulse();
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        check("flush_empty_noop", 96'(bus.line_valid_out), 96'h0);
        send(32'h5555_6666);
        bus.flush_in = 1'b1;
        send(32'h7777_8888);
        bus.flush_in = 1'b0;
        check("flush_concurrent_valid", 96'(bus.line_valid_out), 96'h1);
        check("flush_concurrent_line", bus.line_out, 96'h0000_0000_7777_8888_5555_6666);
        ack_pulse();

        // Reset mid-operation with a held line and a partial line.
        send(32'h4000_0001);
        send(32'h4000_0002);
        send(32'h4000_0003);
        send(32'h4000_0004);
        send(32'h4000_0005);
        #3 rst_in = 1'b0;
        #1;
        check("midrst_line",  bus.line_out, 96'h0);
        check("midrst_valid", 96'(bus.line_valid_out), 96'h0);
        check("midrst_ovf",   96'(bus.overflow_out), 96'h0);
        #1 rst_in = 1'b1;
        send(32'h6000_0001);
        check("post_rst_no_early", 96'(bus.line_valid_out), 96'h0);
        send(32'h6000_0002);
        send(32'h6000_0003);
        check("post_rst_valid", 96'(bus.line_valid_out), 96'h1);
        check("post_rst_line", bus.line_out, 96'h6000_0003_6000_0002_6000_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
